// File: rtl/saa_write_seq_pkg.sv
// ----------------------------------------------------------------------------
// saa_write_seq_pkg : shared types and constants for the SAA1099 write sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package saa_write_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_GAP    = 3'd4
   } state_t;

   typedef struct packed {
      logic       a0;
      logic [7:0] data;
   } saa_wr_t;

   localparam logic [7:0] SAA_REG_CTRL = 8'h1C;
   localparam logic [7:0] SAA_CTRL_RST = 8'h02;
   localparam logic [7:0] SAA_CTRL_EN  = 8'h01;

   localparam int DEF_SETUP_CYC  = 2;
   localparam int DEF_STROBE_CYC = 8;
   localparam int DEF_HOLD_CYC   = 2;
   localparam int DEF_GAP_CYC    = 4;
   localparam int DEF_FIFO_AW    = 2;

   // Power-up write list: even steps select the control register, odd steps
   // write reset-generators then sound-enable.
   function automatic saa_wr_t saa_seq_entry(input logic [1:0] idx);
      saa_wr_t e;
      e.a0   = ~idx[0];
      e.data = idx[0] ? (idx[1] ? SAA_CTRL_EN : SAA_CTRL_RST) : SAA_REG_CTRL;
      return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/saa_wr_fifo.sv
// ----------------------------------------------------------------------------
// saa_wr_fifo : small synchronous FIFO with push/pop/flush and full/empty flags
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module saa_wr_fifo
   import saa_write_seq_pkg::*;
#(
   parameter int AW = DEF_FIFO_AW,
   parameter int W  = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   input  logic         flush,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int          DEPTH   = 1 << AW;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic         push_ok;
   logic         pop_ok;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
   assign pop_ok   = pop & ~empty;
   // A pop frees the head slot in the same cycle, so a push into a full FIFO
   // is still accepted; the head is read out before it is overwritten.
   assign push_ok  = push & (~full | pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

`default_nettype wire

// File: rtl/saa_write_seq.sv
// ----------------------------------------------------------------------------
// saa_write_seq : SAA1099 bus write sequencer; macro SAA_RESET_SEQ_EN adds the
//                 automatic reset/enable writes on each enable rise.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module saa_write_seq
   import saa_write_seq_pkg::*;
#(
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int HOLD_CYC   = DEF_HOLD_CYC,
   parameter int GAP_CYC    = DEF_GAP_CYC,
   parameter int FIFO_AW    = DEF_FIFO_AW
) (
   input  logic       fclk,
   input  logic       rst_n,
   input  logic       wr_stb,
   input  logic       wr_a0,
   input  logic [7:0] wr_data,
   input  logic       saa_en_req,
   output logic       saa_enabled,
   output logic       fifo_full,
   output logic       busy,
   output logic [3:0] drop_cnt,
   output logic       saa_cs_n,
   output logic       saa_wr_n,
   output logic       saa_a0,
   output logic [7:0] saa_d,
   output logic       saa_d_oe
);

   localparam logic [3:0] SETUP_LAST  = 4'(SETUP_CYC - 1);
   localparam logic [3:0] STROBE_LAST = 4'(STROBE_CYC - 1);
   localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYC - 1);
   localparam logic [3:0] GAP_LAST    = 4'(GAP_CYC - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cs_n_q, cs_n_d;
   logic       wr_n_q, wr_n_d;
   logic       a0_q, a0_d;
   logic [7:0] d_q, d_d;
   logic       d_oe_q, d_oe_d;
   logic       en_q, en_d;
   logic [3:0] drop_cnt_q, drop_cnt_d;

   logic       fifo_push;
   logic       fifo_pop;
   logic       fifo_flush;
   logic       fifo_full_w;
   logic       fifo_empty;
   logic [8:0] fifo_head;
   logic       hold_exit;
   logic       seq_go;
   logic       seq_busy;
   saa_wr_t    seq_wr;

   saa_wr_fifo #(
      .AW (FIFO_AW),
      .W  (9)
   ) u_fifo (
      .clk       (fclk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data ({wr_a0, wr_data}),
      .pop       (fifo_pop),
      .flush     (fifo_flush),
      .pop_data  (fifo_head),
      .full      (fifo_full_w),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      cs_n_d    = cs_n_q;
      wr_n_d    = wr_n_q;
      a0_d      = a0_q;
      d_d       = d_q;
      d_oe_d    = d_oe_q;
      fifo_pop  = 1'b0;
      hold_exit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Gating on the request too keeps a queued entry from starting
            // in the cycle the enable is withdrawn.
            if (en_q && saa_en_req && (seq_go || !fifo_empty)) begin
               if (seq_go) begin
                  a0_d = seq_wr.a0;
                  d_d  = seq_wr.data;
               end else begin
                  fifo_pop = 1'b1;
                  a0_d     = fifo_head[8];
                  d_d      = fifo_head[7:0];
               end
               cs_n_d  = 1'b0;
               d_oe_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               wr_n_d  = 1'b0;
               cnt_d   = '0;
               state_d = ST_STROBE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_STROBE: begin
            if (cnt_q == STROBE_LAST) begin
               wr_n_d  = 1'b1;
               cnt_d   = '0;
               state_d = ST_HOLD;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               cs_n_d    = 1'b1;
               d_oe_d    = 1'b0;
               cnt_d     = '0;
               hold_exit = 1'b1;
               state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            cs_n_d  = 1'b1;
            wr_n_d  = 1'b1;
            d_oe_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      fifo_flush = ~saa_en_req;
      fifo_push  = wr_stb & saa_en_req & (~fifo_full_w | fifo_pop);
      drop_cnt_d = drop_cnt_q;
      if (wr_stb && saa_en_req && fifo_full_w && !fifo_pop && (drop_cnt_q != 4'hF)) begin
         drop_cnt_d = drop_cnt_q + 4'd1;
      end
      // The SAA clock may only stop once no write is between CS fall and hold end.
      en_d = en_q;
      if (saa_en_req) begin
         en_d = 1'b1;
      end else if ((state_q == ST_IDLE) || (state_q == ST_GAP) || hold_exit) begin
         en_d = 1'b0;
      end
   end

`ifdef SAA_RESET_SEQ_EN
   logic       seq_act_q, seq_act_d;
   logic [1:0] seq_idx_q, seq_idx_d;

   always_comb begin
      seq_act_d = seq_act_q;
      seq_idx_d = seq_idx_q;
      if (!en_q && en_d) begin
         seq_act_d = 1'b1;
         seq_idx_d = '0;
      end else if (seq_act_q && !saa_en_req &&
                   ((state_q == ST_IDLE) || (state_q == ST_GAP) || hold_exit)) begin
         seq_act_d = 1'b0;
         seq_idx_d = '0;
      end else if (seq_act_q && hold_exit) begin
         if (seq_idx_q == 2'd3) begin
            seq_act_d = 1'b0;
            seq_idx_d = '0;
         end else begin
            seq_idx_d = seq_idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         seq_act_q <= 1'b0;
         seq_idx_q <= '0;
      end else begin
         seq_act_q <= seq_act_d;
         seq_idx_q <= seq_idx_d;
      end
   end

   assign seq_go   = seq_act_q;
   assign seq_busy = seq_act_q;
   assign seq_wr   = saa_seq_entry(seq_idx_q);
`else
   assign seq_go   = 1'b0;
   assign seq_busy = 1'b0;
   assign seq_wr   = '0;
`endif

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         cs_n_q     <= 1'b1;
         wr_n_q     <= 1'b1;
         a0_q       <= 1'b0;
         d_q        <= '0;
         d_oe_q     <= 1'b0;
         en_q       <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cs_n_q     <= cs_n_d;
         wr_n_q     <= wr_n_d;
         a0_q       <= a0_d;
         d_q        <= d_d;
         d_oe_q     <= d_oe_d;
         en_q       <= en_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign saa_enabled = en_q;
   assign fifo_full   = fifo_full_w;
   assign busy        = ~fifo_empty | (state_q != ST_IDLE) | seq_busy;
   assign drop_cnt    = drop_cnt_q;
   assign saa_cs_n    = cs_n_q;
   assign saa_wr_n    = wr_n_q;
   assign saa_a0      = a0_q;
   assign saa_d       = d_q;
   assign saa_d_oe    = d_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_saa_write_seq.sv
// ----------------------------------------------------------------------------
// tb_saa_write_seq : directed self-checking bench for saa_write_seq
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_saa_write_seq;

   logic       fclk       = 1'b0;
   logic       rst_n      = 1'b0;
   logic       wr_stb     = 1'b0;
   logic       wr_a0      = 1'b0;
   logic [7:0] wr_data    = 8'h00;
   logic       saa_en_req = 1'b0;
   logic       saa_enabled;
   logic       fifo_full;
   logic       busy;
   logic [3:0] drop_cnt;
   logic       saa_cs_n;
   logic       saa_wr_n;
   logic       saa_a0;
   logic [7:0] saa_d;
   logic       saa_d_oe;

   saa_write_seq dut (
      .fclk        (fclk),
      .rst_n       (rst_n),
      .wr_stb      (wr_stb),
      .wr_a0       (wr_a0),
      .wr_data     (wr_data),
      .saa_en_req  (saa_en_req),
      .saa_enabled (saa_enabled),
      .fifo_full   (fifo_full),
      .busy        (busy),
      .drop_cnt    (drop_cnt),
      .saa_cs_n    (saa_cs_n),
      .saa_wr_n    (saa_wr_n),
      .saa_a0      (saa_a0),
      .saa_d       (saa_d),
      .saa_d_oe    (saa_d_oe)
   );

   always #9 fclk = ~fclk;

   int cyc = 0;
   always @(posedge fclk) cyc <= cyc + 1;

   typedef struct {
      logic       a0;
      logic [7:0] d;
      int         cs_fall;
      int         wr_fall;
      int         wr_rise;
      int         cs_rise;
      logic       stable;
   } txn_t;

   txn_t q[$];
   int   en_fall_cyc = -1;
   int   errors = 0;
   int   checks = 0;

   // Bus monitor: one record per CS-low window, sampled mid-cycle.
   initial begin
      txn_t cur;
      logic prev_cs = 1'b1;
      logic prev_wr = 1'b1;
      logic prev_en = 1'b0;
      cur = '{a0: 1'b0, d: 8'h00, cs_fall: -1, wr_fall: -1, wr_rise: -1, cs_rise: -1, stable: 1'b1};
      forever begin
         @(negedge fclk);
         if (prev_cs && !saa_cs_n) begin
            cur = '{a0: saa_a0, d: saa_d, cs_fall: cyc, wr_fall: -1, wr_rise: -1, cs_rise: -1, stable: 1'b1};
         end
         if (!saa_cs_n && ((saa_a0 !== cur.a0) || (saa_d !== cur.d) || (saa_d_oe !== 1'b1)))
            cur.stable = 1'b0;
         if (prev_wr && !saa_wr_n) cur.wr_fall = cyc;
         if (!prev_wr && saa_wr_n) cur.wr_rise = cyc;
         if (!prev_cs && saa_cs_n) begin
            cur.cs_rise = cyc;
            q.push_back(cur);
         end
         if (prev_en && !saa_enabled) en_fall_cyc = cyc;
         prev_cs = saa_cs_n;
         prev_wr = saa_wr_n;
         prev_en = saa_enabled;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge fclk);
      #1;
   endtask

   task automatic strobe(input logic a0, input logic [7:0] d);
      wr_a0   = a0;
      wr_data = d;
      wr_stb  = 1'b1;
      tick(1);
      wr_stb  = 1'b0;
   endtask

   task automatic wait_txns(input string tag, input int n, input int budget);
      int k = 0;
      while (q.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      if (q.size() < n) check(tag, q.size(), n);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int k = 0;
      while (busy && k < budget) begin
         tick(1);
         k++;
      end
      if (busy) check(tag, busy, 0);
   endtask

   task automatic wait_wr_low(input string tag);
      int k = 0;
      while (saa_wr_n && k < 40) begin
         tick(1);
         k++;
      end
      if (saa_wr_n) check(tag, saa_wr_n, 0);
   endtask

   // Raise the enable and let any automatic power-up writes finish.
   task automatic enable_settle(input string tag);
      saa_en_req = 1'b1;
      tick(1);
      check({tag, "_en_rise"}, saa_enabled, 1);
      wait_idle({tag, "_settle"}, 300);
      tick(1);
      q.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int   t0;
      txn_t tx;
      int   n_exp;
      logic [8:0] exp_tx [5];

      // Reset state
      tick(3);
      check("rst_cs_n", saa_cs_n, 1);
      check("rst_wr_n", saa_wr_n, 1);
      check("rst_d_oe", saa_d_oe, 0);
      check("rst_a0", saa_a0, 0);
      check("rst_d", saa_d, 8'h00);
      check("rst_enabled", saa_enabled, 0);
      check("rst_full", fifo_full, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop_cnt, 0);
      @(negedge fclk);
      rst_n = 1'b1;
      tick(2);

      // Single address write: latency and full timing window
      enable_settle("t1");
      t0 = cyc;
      strobe(1'b1, 8'h1C);
      wait_txns("t1_timeout", 1, 100);
      if (q.size() >= 1) begin
         tx = q[0];
         check("t1_cs_latency", tx.cs_fall - t0, 2);
         check("t1_setup", tx.wr_fall - tx.cs_fall, 2);
         check("t1_strobe", tx.wr_rise - tx.wr_fall, 8);
         check("t1_hold", tx.cs_rise - tx.wr_rise, 2);
         check("t1_a0", tx.a0, 1);
         check("t1_d", tx.d, 8'h1C);
         check("t1_stable", tx.stable, 1);
      end
      wait_idle("t1_idle", 50);
      q.delete();

      // Fill the FIFO behind an in-flight write so the head is not popped
      // before the queue fills: 0x00..0x03 queue, 0x04 is dropped.
      strobe(1'b0, 8'hAA);
      tick(1);
      for (int i = 0; i < 5; i++) strobe(1'b0, 8'(i));
      check("t2_full", fifo_full, 1);
      check("t2_drop", drop_cnt, 1);
      check("t2_busy", busy, 1);
      wait_txns("t2_timeout", 5, 200);
      if (q.size() >= 5) begin
         check("t2_first_d", q[0].d, 8'hAA);
         for (int i = 1; i < 5; i++) begin
            check($sformatf("t2_d%0d", i), q[i].d, 32'(i - 1));
            check($sformatf("t2_period%0d", i), q[i].cs_fall - q[i-1].cs_fall, 17);
         end
      end
      wait_idle("t2_idle", 50);
      tick(10);
      check("t2_size", q.size(), 5);
      check("t2_drop_after", drop_cnt, 1);
      check("t2_full_after", fifo_full, 0);
      q.delete();

      // Disable mid-strobe with two entries queued
      en_fall_cyc = -1;
      strobe(1'b0, 8'h11);
      strobe(1'b0, 8'h22);
      strobe(1'b0, 8'h33);
      wait_wr_low("t3_wr_low");
      tick(2);
      saa_en_req = 1'b0;
      wait_txns("t3_timeout", 1, 50);
      tick(40);
      check("t3_size", q.size(), 1);
      if (q.size() >= 1) begin
         tx = q[0];
         check("t3_d", tx.d, 8'h11);
         check("t3_strobe", tx.wr_rise - tx.wr_fall, 8);
         check("t3_hold", tx.cs_rise - tx.wr_rise, 2);
         check("t3_en_fall", en_fall_cyc, tx.cs_rise);
      end
      check("t3_enabled", saa_enabled, 0);
      check("t3_busy", busy, 0);
      q.delete();

      // Asynchronous reset during STROBE
      enable_settle("t4");
      strobe(1'b0, 8'h44);
      strobe(1'b0, 8'h55);
      strobe(1'b0, 8'h66);
      wait_wr_low("t4_wr_low");
      tick(2);
      #3;
      rst_n = 1'b0;
      #1;
      check("t4_cs_n", saa_cs_n, 1);
      check("t4_wr_n", saa_wr_n, 1);
      check("t4_d_oe", saa_d_oe, 0);
      saa_en_req = 1'b0;
      tick(2);
      @(negedge fclk);
      rst_n = 1'b1;
      tick(2);
      check("t4_busy", busy, 0);
      check("t4_full", fifo_full, 0);
      check("t4_drop", drop_cnt, 0);
      check("t4_enabled", saa_enabled, 0);
      q.delete();

      // Drop counter saturation
      enable_settle("t5");
      strobe(1'b0, 8'h77);
      tick(1);
      for (int i = 0; i < 5; i++) strobe(1'b0, 8'(i));
      check("t5_drop_first", drop_cnt, 1);
      for (int i = 5; i < 24; i++) strobe(1'b0, 8'(i));
      check("t5_drop_sat", drop_cnt, 15);
      saa_en_req = 1'b0;
      wait_idle("t5_idle", 100);
      tick(2);
      check("t5_enabled_off", saa_enabled, 0);
      check("t5_drop_hold", drop_cnt, 15);
      q.delete();

      // Enable rise with a pending user write
`ifdef SAA_RESET_SEQ_EN
      n_exp = 5;
      exp_tx[0] = {1'b1, 8'h1C};
      exp_tx[1] = {1'b0, 8'h02};
      exp_tx[2] = {1'b1, 8'h1C};
      exp_tx[3] = {1'b0, 8'h01};
      exp_tx[4] = {1'b0, 8'h55};
`else
      n_exp = 1;
      exp_tx[0] = {1'b0, 8'h55};
      for (int i = 1; i < 5; i++) exp_tx[i] = '0;
`endif
      saa_en_req = 1'b1;
      wr_a0      = 1'b0;
      wr_data    = 8'h55;
      wr_stb     = 1'b1;
      tick(1);
      wr_stb     = 1'b0;
      check("t6_en_rise", saa_enabled, 1);
      wait_txns("t6_timeout", n_exp, 300);
      tick(30);
      check("t6_size", q.size(), n_exp);
      for (int i = 0; i < n_exp; i++) begin
         if (q.size() > i) check($sformatf("t6_tx%0d", i), {q[i].a0, q[i].d}, exp_tx[i]);
      end
      check("t6_busy", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/saa_write_seq.md
Name: saa_write_seq

Overview:
- Write sequencer for the SAA1099 bus, in the fclk (56 MHz) domain.
- Takes single-cycle write requests decoded from Z80 port writes and buffers them in a small FIFO.
- Drives the SAA /CS, /WR, A0 and data pins with programmable setup/strobe/hold timing.
- Owns the saa_enabled signal that gates the 8 MHz SAA clock generator, so that clock is never stopped mid-write.

Parameters:
- SETUP_CYC, 2, fclk cycles that A0/data/CS are valid before /WR falls (1..15).
- STROBE_CYC, 8, fclk cycles /WR is held low (1..15).
- HOLD_CYC, 2, fclk cycles A0/data/CS stay valid after /WR rises (1..15).
- GAP_CYC, 4, fclk cycles of idle bus (CS high) between transactions (0..15).
- FIFO_AW, 2, log2 of FIFO depth (depth 4).

Ports:
- fclk  in  1  56 MHz master clock
- rst_n  in  1  asynchronous active-low reset
- wr_stb  in  1  one-fclk write request, already synchronised
- wr_a0  in  1  0 = data register, 1 = address register
- wr_data  in  8  byte to write
- saa_en_req  in  1  SAA enable from the config register
- saa_enabled  out  1  gates the SAA clock generator
- fifo_full  out  1  FIFO full; a wr_stb arriving while full is dropped
- busy  out  1  FIFO non-empty or a transaction is in progress
- drop_cnt  out  4  saturating count of dropped writes
- saa_cs_n  out  1  SAA chip select
- saa_wr_n  out  1  SAA write strobe
- saa_a0  out  1  SAA A0
- saa_d  out  8  SAA data bus
- saa_d_oe  out  1  data bus output enable

Behaviour:
- Clock and reset: single clock fclk; reset rst_n is asynchronous and active-low.
- Reset values:
  - saa_cs_n = 1, saa_wr_n = 1, saa_d_oe = 0.
  - saa_a0 = 0, saa_d = 0.
  - saa_enabled = 0, fifo_full = 0, busy = 0, drop_cnt = 0.
  - FIFO emptied; FSM in IDLE.
- FIFO:
  - 9-bit entries {a0, data}, depth 2^FIFO_AW.
  - Pointers are FIFO_AW+1 bits so full and empty can be told apart; they wrap naturally.
  - wr_stb while full: entry dropped, drop_cnt increments, saturating at 15.
  - wr_stb while saa_en_req = 0: entry dropped, drop_cnt unchanged.
  - Simultaneous push and pop while full: the push is accepted.
- FSM states and transitions:
  - IDLE: if FIFO non-empty and saa_enabled = 1, pop the head into the output registers (a0, d), drive cs_n = 0 and d_oe = 1, then go to SETUP.
  - SETUP: count SETUP_CYC cycles, then drive wr_n = 0 and go to STROBE.
  - STROBE: count STROBE_CYC cycles, then drive wr_n = 1 and go to HOLD.
  - HOLD: count HOLD_CYC cycles, then drive cs_n = 1 and d_oe = 0 and go to GAP; if GAP_CYC = 0, go straight to IDLE.
  - GAP: count GAP_CYC cycles, then go to IDLE.
- Latency: with defaults, wr_stb into an empty FIFO gives cs_n falling 2 cycles later (one cycle for the FIFO write, one for the IDLE pop).
- Back-to-back period with defaults = 1 + 2 + 8 + 2 + 4 = 17 cycles.
- All bus outputs are registered; no glitches.
- Enable handling:
  - saa_enabled rises 1 cycle after saa_en_req rises.
  - When saa_en_req falls: the FIFO is flushed in the same cycle; an in-flight transaction completes through HOLD; saa_enabled falls on the cycle the FSM leaves HOLD. If the FSM is IDLE or in GAP, saa_enabled falls in the next cycle.
  - saa_en_req rising again while the drain is still in progress: saa_enabled stays high.
- busy = FIFO non-empty OR FSM not in IDLE.
- Reset mid-transaction: the bus returns to idle immediately (asynchronously); no completion of the write.

Optional Feature:
- Macro name: SAA_RESET_SEQ_EN.
- Defined: on each saa_enabled rising edge, before any FIFO traffic, the FSM issues an internal 4-write sequence:
  - addr 0x1C, data 0x02 (reset generators);
  - addr 0x1C, data 0x01 (sound enable).
  - The sequence uses the normal timing, holds busy = 1, and does not consume FIFO entries.
  - Disable during the sequence aborts it after the current transaction.
- Undefined: no automatic writes; saa_enabled rising has no bus effect.

Decomposition:
- Shared package:
  - FSM state encoding;
  - the SAA control register constants (SAA_REG_CTRL = 8'h1C, SAA_CTRL_RST = 8'h02, SAA_CTRL_EN = 8'h01);
  - the default timing constants.
- One sub-module, saa_wr_fifo:
  - parameterised sync FIFO with push/pop/flush, full/empty outputs.

Test Plan:
- Reset then saa_en_req = 1; single wr_stb with a0 = 1, data 0x1C: saa_enabled = 1 after 1 cycle; cs_n low 2 cycles after wr_stb; wr_n low exactly 8 cycles starting 2 cycles after cs_n falls; a0 = 1 and d = 0x1C stable for the whole window; cs_n high after hold.
- Five consecutive wr_stb (data 0x00..0x04): first four written in order 17 cycles apart; fifth dropped; fifo_full asserted; drop_cnt = 1.
- Deassert saa_en_req mid-STROBE with 2 entries queued: current write completes with full timing; queued entries never appear on the bus; saa_enabled falls on the cycle the FSM leaves HOLD.
- rst_n low during STROBE: cs_n, wr_n go high and d_oe goes low immediately; FIFO empty and busy = 0 after release.
- 20 wr_stb into a full FIFO: drop_cnt saturates at 15.
- With SAA_RESET_SEQ_EN: enable rise gives the bus writes (1,0x1C), (0,0x02), (1,0x1C), (0,0x01) before a pending user write (0,0x55); without the macro only (0,0x55) appears.
